// File: rtl/alu_pkg.sv
// Shared encodings for alu_mdu: work_type field positions, funct3 codes, FSM states.
// The DIV state exists only when ALU_MDU_DIV_EN is defined.
package alu_pkg;

    localparam int WT_M     = 5;
    localparam int WT_F3_HI = 4;
    localparam int WT_F3_LO = 2;
    localparam int WT_ALT   = 1;
    localparam int WT_BR    = 0;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
`ifdef ALU_MDU_DIV_EN
        ST_DIV  = 2'd2,
`endif
        ST_DONE = 2'd3
    } state_t;

    function automatic logic is_div_op(input logic [2:0] f3);
        return (f3 == F3_DIV) || (f3 == F3_DIVU) || (f3 == F3_REM) || (f3 == F3_REMU);
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative sign-magnitude multiplier (shift-add) and, with ALU_MDU_DIV_EN, restoring divider.
// One bit per step; result is presented combinationally alongside the final step.
module mdu_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] r1,
    input  logic [XLEN-1:0] r2,
    output logic            last,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);

    logic [XLEN-1:0]   hi_reg, lo_reg, b_reg, hi_next, lo_next;
    logic [CW-1:0]     cnt_reg;
    logic [2:0]        f3_reg;
    logic              neg_reg;
    logic              a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     sum;
    logic [2*XLEN-1:0] prod;
`ifdef ALU_MDU_DIV_EN
    logic              rneg_reg;
    logic              ge;
    logic [XLEN-1:0]   diff;
`endif

    always_comb begin
        a_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU);
        b_signed = (funct3 == F3_MULH);
`ifdef ALU_MDU_DIV_EN
        if (is_div_op(funct3)) begin
            a_signed = (funct3 == F3_DIV) || (funct3 == F3_REM);
            b_signed = a_signed;
        end
`endif
        a_neg = a_signed & r1[XLEN-1];
        b_neg = b_signed & r2[XLEN-1];
        a_mag = a_neg ? -r1 : r1;
        b_mag = b_neg ? -r2 : r2;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_reg   <= '0;
            lo_reg   <= '0;
            b_reg    <= '0;
            cnt_reg  <= '0;
            f3_reg   <= '0;
            neg_reg  <= 1'b0;
`ifdef ALU_MDU_DIV_EN
            rneg_reg <= 1'b0;
`endif
        end else if (load) begin
            cnt_reg <= '0;
            f3_reg  <= funct3;
            hi_reg  <= '0;
            lo_reg  <= b_mag;
            b_reg   <= a_mag;
            neg_reg <= a_neg ^ b_neg;
`ifdef ALU_MDU_DIV_EN
            rneg_reg <= a_neg;
            if (is_div_op(funct3)) begin
                lo_reg  <= a_mag;
                b_reg   <= b_mag;
                // A zero divisor yields all-ones quotient, which must not be negated.
                neg_reg <= (a_neg ^ b_neg) && (r2 != '0);
            end
`endif
        end else if (step) begin
            cnt_reg <= cnt_reg + 1'b1;
            hi_reg  <= hi_next;
            lo_reg  <= lo_next;
        end
    end

    always_comb begin
        sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_reg} : '0);
        {hi_next, lo_next} = {sum, lo_reg[XLEN-1:1]};
`ifdef ALU_MDU_DIV_EN
        ge   = {hi_reg, lo_reg[XLEN-1]} >= {1'b0, b_reg};
        diff = {hi_reg[XLEN-2:0], lo_reg[XLEN-1]} - b_reg;
        if (is_div_op(f3_reg)) begin
            if (ge) begin
                hi_next = diff;
                lo_next = {lo_reg[XLEN-2:0], 1'b1};
            end else begin
                hi_next = {hi_reg[XLEN-2:0], lo_reg[XLEN-1]};
                lo_next = {lo_reg[XLEN-2:0], 1'b0};
            end
        end
`endif
    end

    assign last = (cnt_reg == CW'(XLEN - 1));

    always_comb begin
        prod = {hi_next, lo_next};
        if (neg_reg) prod = -prod;
        case (f3_reg)
            F3_MUL:                       result = prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: result = prod[2*XLEN-1:XLEN];
`ifdef ALU_MDU_DIV_EN
            F3_DIV, F3_DIVU:              result = neg_reg ? -lo_next : lo_next;
            F3_REM, F3_REMU:              result = rneg_reg ? -hi_next : hi_next;
`endif
            default:                      result = '0;
        endcase
    end

endmodule

// File: rtl/alu_mdu.sv
// Integer ALU / branch compare (single cycle) plus iterative M-extension unit.
// Define ALU_MDU_DIV_EN to build the divider; otherwise div/rem return 0 in one cycle.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int ROB_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       work_type,
    input  logic [XLEN-1:0]  r1,
    input  logic [XLEN-1:0]  r2,
    input  logic [ROB_W-1:0] inst_rob_id,
    output logic             out_valid,
    output logic [ROB_W-1:0] out_rob_id,
    output logic [XLEN-1:0]  out_value
);
    localparam int SHW = $clog2(XLEN);

    state_t            state_reg, state_next;
    logic [ROB_W-1:0]  tag_reg;
    logic [2:0]        f3;
    logic              is_m, accept, mdu_start, mdu_busy, step, last;
    logic              eq, lt, ltu, br;
    logic [SHW-1:0]    shamt;
    logic [XLEN-1:0]   sra_value, alu_value, base_value, mdu_result;

    assign f3       = work_type[WT_F3_HI:WT_F3_LO];
    assign is_m     = work_type[WT_M];
    assign in_ready = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
    assign accept   = in_valid && in_ready && rdy && !flush;
`ifdef ALU_MDU_DIV_EN
    assign mdu_start = accept && is_m;
    assign mdu_busy  = (state_reg == ST_MUL) || (state_reg == ST_DIV);
`else
    // Without the divider, div-class ops complete through the single-cycle path.
    assign mdu_start = accept && is_m && !is_div_op(f3);
    assign mdu_busy  = (state_reg == ST_MUL);
`endif
    assign step = rdy && !flush && mdu_busy;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                state_next = ST_IDLE;
                if (mdu_start) state_next = ST_MUL;
`ifdef ALU_MDU_DIV_EN
                if (mdu_start && is_div_op(f3)) state_next = ST_DIV;
`endif
            end
            ST_MUL:  if (last) state_next = ST_DONE;
`ifdef ALU_MDU_DIV_EN
            ST_DIV:  if (last) state_next = ST_DONE;
`endif
            default: state_next = ST_IDLE;
        endcase
        if (flush) state_next = ST_IDLE;
    end

    assign shamt     = r2[SHW-1:0];
    assign eq        = (r1 == r2);
    assign lt        = ($signed(r1) < $signed(r2));
    assign ltu       = (r1 < r2);
    assign sra_value = $signed(r1) >>> shamt;

    always_comb begin
        case (f3)
            F3_ADD:  alu_value = work_type[WT_ALT] ? (r1 - r2) : (r1 + r2);
            F3_SLL:  alu_value = r1 << shamt;
            F3_SLT:  alu_value = {{(XLEN-1){1'b0}}, lt};
            F3_SLTU: alu_value = {{(XLEN-1){1'b0}}, ltu};
            F3_XOR:  alu_value = r1 ^ r2;
            F3_SR:   alu_value = work_type[WT_ALT] ? sra_value : (r1 >> shamt);
            F3_OR:   alu_value = r1 | r2;
            default: alu_value = r1 & r2;
        endcase
        case (f3)
            F3_BEQ:  br = eq;
            F3_BNE:  br = !eq;
            F3_BLT:  br = lt;
            F3_BGE:  br = !lt;
            F3_BLTU: br = ltu;
            F3_BGEU: br = !ltu;
            default: br = 1'b0;
        endcase
        if (is_m)                   base_value = '0;
        else if (work_type[WT_BR])  base_value = {{(XLEN-1){1'b0}}, br};
        else                        base_value = alu_value;
    end

    mdu_iter #(.XLEN(XLEN)) u_mdu_iter (
        .clk    (clk),
        .rst    (rst),
        .load   (mdu_start),
        .step   (step),
        .funct3 (f3),
        .r1     (r1),
        .r2     (r2),
        .last   (last),
        .result (mdu_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            tag_reg    <= '0;
            out_valid  <= 1'b0;
            out_rob_id <= '0;
            out_value  <= '0;
        end else if (rdy) begin
            state_reg <= state_next;
            if (mdu_start) tag_reg <= inst_rob_id;
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept && !mdu_start) begin
                out_valid  <= 1'b1;
                out_rob_id <= inst_rob_id;
                out_value  <= base_value;
            end else if (step && last) begin
                out_valid  <= 1'b1;
                out_rob_id <= tag_reg;
                out_value  <= mdu_result;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand/result width, legal 8..64.
REQ-002 SHALL have parameter ROB_W, default 4: ROB tag width.
REQ-003 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port rdy  input  1  global enable; low freezes all state and outputs.
REQ-006 SHALL have port flush  input  1  discard in-flight op.
REQ-007 SHALL have port in_valid  input  1  op offered.
REQ-008 SHALL have port in_ready  output  1  unit can accept an op this cycle.
REQ-009 SHALL have port work_type  input  6  [5] M-class, [4:2] funct3, [1] sub/sra, [0] branch-compare.
REQ-010 SHALL have ports r1, r2  input  XLEN  operands.
REQ-011 SHALL have port inst_rob_id  input  ROB_W  tag of offered op.
REQ-012 SHALL have ports out_valid  output  1, out_rob_id  output  ROB_W, out_value  output  XLEN  result.

Function
REQ-013 SHALL accept an op when in_valid && in_ready && rdy && !flush.
REQ-014 SHALL, for work_type[5]=0, produce the base integer/branch result (add/sub, sll, slt, sltu, xor, srl/sra, or, and; beq, bne, blt, bge, bltu, bgeu as 0/1) with out_valid high exactly 1 cycle after acceptance.
REQ-015 SHALL use shift amount r2[log2(XLEN)-1:0].
REQ-016 SHALL, for work_type[5]=1, execute funct3 0..3 as mul, mulh, mulhsu, mulhu and 4..7 as div, divu, rem, remu.
REQ-017 SHALL implement M ops iteratively, one bit per enabled cycle; out_valid asserts exactly XLEN+1 cycles after acceptance.
REQ-018 SHALL use FSM states IDLE, MUL, DIV, DONE: IDLE->MUL/DIV on M-op accept, MUL/DIV->DONE when bit counter reaches XLEN-1, DONE->IDLE unconditionally.
REQ-019 SHALL drive in_ready=1 only in IDLE or DONE; base op may be accepted in DONE (back-to-back).
REQ-020 SHALL hold out_valid for exactly one enabled cycle per op; out_rob_id, out_value hold last result otherwise.
REQ-021 SHALL return all-ones quotient and remainder=r1 on divide by zero, no exception.
REQ-022 SHALL return quotient=most-negative, remainder=0 for signed most-negative / -1.
REQ-023 SHALL, on flush, return to IDLE and deassert out_valid next cycle; an op offered with flush is not accepted.
REQ-024 SHALL, when rdy=0, freeze FSM, counter and outputs; out_valid resumes its pulse when rdy returns.

Reset
REQ-025 SHALL, on rst, asynchronously set state IDLE, counter 0, out_valid 0, out_rob_id 0, out_value 0.
REQ-026 SHALL, on rst mid-operation, abandon the op with no result produced.

Configuration
REQ-027 SHALL compile the divider only when ALU_MDU_DIV_EN is defined.
REQ-028 SHALL, without ALU_MDU_DIV_EN, complete div/divu/rem/remu in 1 cycle with out_value 0 and omit the DIV state; mul ops unaffected.

Structure
REQ-029 SHALL take work_type field positions, funct3 encodings and FSM state encoding from shared package alu_pkg.
REQ-030 SHALL place the iterative multiply/divide datapath in sub-module mdu_iter; base ALU stays inline.

Verification
REQ-031 SHALL cover: add 5+7, work_type=0 -> out_valid 1 cycle later, value 12, tag echoed.
REQ-032 SHALL cover: mulh 0x80000000 x 0x80000000 (XLEN=32) -> value 0x40000000 after 33 cycles, in_ready low cycles 1..32.
REQ-033 SHALL cover: div 100/0 -> 0xFFFFFFFF; rem 100/0 -> 100; div 0x80000000/-1 -> 0x80000000, rem -> 0.
REQ-034 SHALL cover: flush 10 cycles into divu -> no out_valid, in_ready high next cycle, following add returns correctly.
REQ-035 SHALL cover: rdy low 5 cycles mid-mul -> result delayed exactly 5 cycles, value unchanged.
REQ-036 SHALL cover: rst asserted mid-div with clk stopped -> outputs zero immediately, state IDLE.
